// File: rtl/dmem_ctrl_pkg.sv
// Shared types and sizing for the retire-stage data-memory controller.
package dmem_ctrl_pkg;

    localparam int unsigned STB_DEPTH         = 4;
    localparam int unsigned ADDR_WIDTH        = 32;
    localparam int unsigned DATA_WIDTH        = 32;
    localparam int unsigned PHY_RF_ADDR_WIDTH = 6;
    localparam int unsigned STB_PTR_WIDTH     = $clog2(STB_DEPTH);

    typedef logic [STB_PTR_WIDTH-1:0] stb_ptr_t;
    typedef logic [STB_PTR_WIDTH:0]   stb_cnt_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } stb_entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StLdReq,
        StLdWait,
        StStReq,
        StStWait
    } dmem_ctrl_state_t;

endpackage

// File: rtl/dmem_stb.sv
// In-order store buffer: circular queue with a youngest-match address search.
module dmem_stb
    import dmem_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq,
    input  stb_entry_t            enq_entry,
    input  logic                  deq,
    output stb_entry_t            head_entry,
    output logic                  full,
    output logic                  empty,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data
);

    stb_entry_t entries_q [STB_DEPTH];
    stb_ptr_t   head_q, tail_q;
    stb_cnt_t   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + 1'b1;
            if (deq) head_q <= head_q + 1'b1;
            if (enq && !deq) begin
                count_q <= count_q + 1'b1;
            end else if (!enq && deq) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Payload needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (enq) entries_q[tail_q] <= enq_entry;
    end

    assign head_entry = entries_q[head_q];
    assign full       = (count_q == stb_cnt_t'(STB_DEPTH));
    assign empty      = (count_q == '0);

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        stb_ptr_t idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < STB_DEPTH; k++) begin
            idx = head_q + stb_ptr_t'(k);
            if ((stb_cnt_t'(k) < count_q) && (entries_q[idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entries_q[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Retire-stage data-memory sequencer: store buffer drain, load forwarding and
// miss loads onto a single-ported handshaked memory, one transaction at a time.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ret_valid,
    input  logic                         ret_store,
    input  logic                         ret_load,
    input  logic [ADDR_WIDTH-1:0]        ret_addr,
    input  logic [DATA_WIDTH-1:0]        ret_data,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] ret_dest,
    output logic                         ret_stall,
    output logic                         ld_wb_valid,
    output logic [PHY_RF_ADDR_WIDTH-1:0] ld_wb_addr,
    output logic [DATA_WIDTH-1:0]        ld_wb_data,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_we,
    output logic [ADDR_WIDTH-1:0]        mem_req_addr,
    output logic [DATA_WIDTH-1:0]        mem_req_wdata,
    input  logic                         mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]        mem_resp_rdata,
    output logic                         stb_empty
);

    dmem_ctrl_state_t state_q, state_d;

    logic                  stb_full, stb_is_empty, stb_hit;
    logic [DATA_WIDTH-1:0] stb_hit_data;
    stb_entry_t            stb_head, enq_entry;
    logic                  load_miss, ld_resp, ret_accept, enq, deq;

    logic                         ld_wb_valid_q;
    logic [PHY_RF_ADDR_WIDTH-1:0] ld_wb_addr_q;
    logic [DATA_WIDTH-1:0]        ld_wb_data_q;
    logic                         req_we_q;
    logic [ADDR_WIDTH-1:0]        req_addr_q;
    logic [DATA_WIDTH-1:0]        req_wdata_q;

    assign enq_entry = '{addr: ret_addr, data: ret_data};

    dmem_stb u_stb (
        .clk        (clk),
        .rst        (rst),
        .enq        (enq),
        .enq_entry  (enq_entry),
        .deq        (deq),
        .head_entry (stb_head),
        .full       (stb_full),
        .empty      (stb_is_empty),
        .lookup_addr(ret_addr),
        .hit        (stb_hit),
        .hit_data   (stb_hit_data)
    );

    assign load_miss  = ret_valid && ret_load && !stb_hit;
    assign ld_resp    = (state_q == StLdWait) && mem_resp_valid;
    // Full is judged before this cycle's dequeue, so a full-STB store always waits a cycle.
    assign ret_stall  = ret_valid && ((ret_store && stb_full) || (load_miss && !ld_resp));
    assign ret_accept = ret_valid && !ret_stall;
    assign enq        = ret_accept && ret_store;
    assign deq        = (state_q == StStWait) && mem_resp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_miss) begin
                    state_d = StLdReq;
                end else if (!stb_is_empty) begin
                    state_d = StStReq;
                end
            end
            StLdReq:  if (mem_req_ready)  state_d = StLdWait;
            StLdWait: if (mem_resp_valid) state_d = StIdle;
            StStReq:  if (mem_req_ready)  state_d = StStWait;
            StStWait: if (mem_resp_valid) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Request fields are latched on leaving idle and held through the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (state_q == StIdle && state_d == StLdReq) begin
            req_we_q   <= 1'b0;
            req_addr_q <= ret_addr;
        end else if (state_q == StIdle && state_d == StStReq) begin
            req_we_q    <= 1'b1;
            req_addr_q  <= stb_head.addr;
            req_wdata_q <= stb_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_wb_valid_q <= 1'b0;
            ld_wb_addr_q  <= '0;
            ld_wb_data_q  <= '0;
        end else begin
            ld_wb_valid_q <= ret_accept && ret_load;
            if (ret_accept && ret_load) begin
                ld_wb_addr_q <= ret_dest;
                ld_wb_data_q <= stb_hit ? stb_hit_data : mem_resp_rdata;
            end
        end
    end

    assign mem_req_valid = (state_q == StLdReq) || (state_q == StStReq);
    assign mem_req_we    = req_we_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign ld_wb_valid   = ld_wb_valid_q;
    assign ld_wb_addr    = ld_wb_addr_q;
    assign ld_wb_data    = ld_wb_data_q;
    assign stb_empty     = stb_is_empty && (state_q != StStReq) && (state_q != StStWait);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl with a latency-programmable memory model.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         ret_valid = 1'b0, ret_store = 1'b0, ret_load = 1'b0;
    logic [ADDR_WIDTH-1:0]        ret_addr = '0;
    logic [DATA_WIDTH-1:0]        ret_data = '0;
    logic [PHY_RF_ADDR_WIDTH-1:0] ret_dest = '0;
    logic                         ret_stall, ld_wb_valid;
    logic [PHY_RF_ADDR_WIDTH-1:0] ld_wb_addr;
    logic [DATA_WIDTH-1:0]        ld_wb_data;
    logic                         mem_req_valid, mem_req_we;
    logic                         mem_req_ready = 1'b0;
    logic [ADDR_WIDTH-1:0]        mem_req_addr;
    logic [DATA_WIDTH-1:0]        mem_req_wdata;
    logic                         mem_resp_valid = 1'b0;
    logic [DATA_WIDTH-1:0]        mem_resp_rdata = '0;
    logic                         stb_empty;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ret_valid     (ret_valid),
        .ret_store     (ret_store),
        .ret_load      (ret_load),
        .ret_addr      (ret_addr),
        .ret_data      (ret_data),
        .ret_dest      (ret_dest),
        .ret_stall     (ret_stall),
        .ld_wb_valid   (ld_wb_valid),
        .ld_wb_addr    (ld_wb_addr),
        .ld_wb_data    (ld_wb_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata),
        .stb_empty     (stb_empty)
    );

    // Memory model: one outstanding request, response pulse lat cycles after the handshake.
    logic [31:0] mem [1024];
    int          lat = 2;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic        p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic        log_we [64];
    logic [31:0] log_addr [64];
    logic [31:0] log_wdata [64];
    int          n_req = 0;
    int          n_rd = 0;

    always @(posedge clk) begin
        mem_resp_valid <= 1'b0;
        if (rst) begin
            pend <= 1'b0;
        end else if (pend) begin
            if (cnt <= 1) begin
                mem_resp_valid <= 1'b1;
                mem_resp_rdata <= mem[p_addr[11:2]];
                if (p_we) mem[p_addr[11:2]] <= p_wdata;
                pend <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (mem_req_valid && mem_req_ready) begin
            pend             <= 1'b1;
            cnt              <= lat;
            p_we             <= mem_req_we;
            p_addr           <= mem_req_addr;
            p_wdata          <= mem_req_wdata;
            log_we[n_req]    <= mem_req_we;
            log_addr[n_req]  <= mem_req_addr;
            log_wdata[n_req] <= mem_req_wdata;
            n_req            <= n_req + 1;
            if (!mem_req_we) n_rd <= n_rd + 1;
        end
    end

    typedef struct {
        logic        st;
        logic        ld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  dest;
        logic        exp_stall;
        logic        exp_wb;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ld, input logic [31:0] a,
                         input logic [31:0] d, input logic [5:0] dest);
        ret_valid = st | ld;
        ret_store = st;
        ret_load  = ld;
        ret_addr  = a;
        ret_data  = d;
        ret_dest  = dest;
    endtask

    task automatic check_reset(input string p);
        check({p, " ret_stall"}, 64'(ret_stall), 0);
        check({p, " ld_wb_valid"}, 64'(ld_wb_valid), 0);
        check({p, " ld_wb_addr"}, 64'(ld_wb_addr), 0);
        check({p, " ld_wb_data"}, 64'(ld_wb_data), 0);
        check({p, " mem_req_valid"}, 64'(mem_req_valid), 0);
        check({p, " mem_req_we"}, 64'(mem_req_we), 0);
        check({p, " mem_req_addr"}, 64'(mem_req_addr), 0);
        check({p, " mem_req_wdata"}, 64'(mem_req_wdata), 0);
        check({p, " stb_empty"}, 64'(stb_empty), 1);
    endtask

    task automatic wait_stb_empty(input string name, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (stb_empty) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 1);
    endtask

    // Called mid-cycle; counts sampled cycles with ret_stall high.
    task automatic wait_unstall(input string name, input int bound, output int n);
        bit ok = 1'b0;
        n = 0;
        for (int i = 0; i < bound; i++) begin
            if (!ret_stall) begin
                ok = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
            #1;
        end
        check(name, 64'(ok), 1);
    endtask

    task automatic check_req(input string name, input int idx, input logic we,
                             input logic [31:0] a, input logic [31:0] d);
        check({name, " we"}, 64'(log_we[idx]), 64'(we));
        check({name, " addr"}, 64'(log_addr[idx]), 64'(a));
        if (we) check({name, " wdata"}, 64'(log_wdata[idx]), 64'(d));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int base, base_rd, n;
        bit hs;

        vecs[0] = '{1'b1, 1'b0, 32'h200, 32'h11, 6'd0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h200, 32'h22, 6'd0, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h200, 32'h0,  6'd5, 1'b0, 1'b1, 32'h22};
        vecs[3] = '{1'b1, 1'b0, 32'h204, 32'h33, 6'd0, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 32'h204, 32'h0,  6'd7, 1'b0, 1'b1, 32'h33};
        vecs[5] = '{1'b1, 1'b0, 32'h208, 32'h44, 6'd0, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'h200, 32'h0,  6'd1, 1'b0, 1'b1, 32'h22};
        vecs[7] = '{1'b1, 1'b0, 32'h20C, 32'h55, 6'd0, 1'b1, 1'b0, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        // Three stores draining in order
        mem_req_ready = 1'b1;
        lat  = 2;
        base = n_req;
        base_rd = n_rd;
        @(negedge clk); drive(1, 0, 32'h100, 32'hA, 0); #1 check("t1 st0 stall", 64'(ret_stall), 0);
        @(negedge clk); drive(1, 0, 32'h104, 32'hB, 0); #1 check("t1 st1 stall", 64'(ret_stall), 0);
        @(negedge clk); drive(1, 0, 32'h100, 32'hC, 0); #1 check("t1 st2 stall", 64'(ret_stall), 0);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        check("t1 stb_empty busy", 64'(stb_empty), 0);
        wait_stb_empty("t1 drain", 100);
        check_req("t1 req0", base + 0, 1, 32'h100, 32'hA);
        check_req("t1 req1", base + 1, 1, 32'h104, 32'hB);
        check_req("t1 req2", base + 2, 1, 32'h100, 32'hC);
        check("t1 mem 0x100", 64'(mem[32'h100 >> 2]), 64'hC);
        check("t1 no reads", 64'(n_rd - base_rd), 0);

        // Miss load with 3-cycle memory
        @(negedge clk); drive(1, 0, 32'h300, 32'hDEAD, 0);
        @(negedge clk); drive(1, 0, 32'h400, 32'hBEEF, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        wait_stb_empty("t3 preload drain", 100);
        lat = 3;
        base_rd = n_rd;
        @(negedge clk); drive(0, 1, 32'h300, 0, 9);
        #1 wait_unstall("t3 unstall", 30, n);
        check("t3 stall cycles", 64'(n), 5);
        @(posedge clk); #1;
        check("t3 wb_valid", 64'(ld_wb_valid), 1);
        check("t3 wb_addr", 64'(ld_wb_addr), 9);
        check("t3 wb_data", 64'(ld_wb_data), 64'hDEAD);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("t3 wb pulse", 64'(ld_wb_valid), 0);
        check("t3 one read", 64'(n_rd - base_rd), 1);

        // Forwarding and full-STB stall with memory held off
        mem_req_ready = 1'b0;
        lat  = 2;
        base = n_req;
        base_rd = n_rd;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].st, vecs[i].ld, vecs[i].addr, vecs[i].data, vecs[i].dest);
            #1 check($sformatf("vec%0d stall", i), 64'(ret_stall), 64'(vecs[i].exp_stall));
            @(posedge clk); #1;
            check($sformatf("vec%0d wb_valid", i), 64'(ld_wb_valid), 64'(vecs[i].exp_wb));
            if (vecs[i].exp_wb) begin
                check($sformatf("vec%0d wb_addr", i), 64'(ld_wb_addr), 64'(vecs[i].dest));
                check($sformatf("vec%0d wb_data", i), 64'(ld_wb_data), 64'(vecs[i].exp_wb_data));
            end
        end
        check("t4 held req_valid", 64'(mem_req_valid), 1);
        check("t4 held req_we", 64'(mem_req_we), 1);
        check("t4 held req_addr", 64'(mem_req_addr), 64'h200);
        check("t4 held req_wdata", 64'(mem_req_wdata), 64'h11);
        @(negedge clk); mem_req_ready = 1'b1;
        #1 wait_unstall("t4 unstall", 30, n);
        check("t4 stall cycles", 64'(n), 4);
        @(posedge clk);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        wait_stb_empty("t4 drain", 200);
        check_req("t4 req0", base + 0, 1, 32'h200, 32'h11);
        check_req("t4 req1", base + 1, 1, 32'h200, 32'h22);
        check_req("t4 req2", base + 2, 1, 32'h204, 32'h33);
        check_req("t4 req3", base + 3, 1, 32'h208, 32'h44);
        check_req("t4 req4", base + 4, 1, 32'h20C, 32'h55);
        check("t2 no reads", 64'(n_rd - base_rd), 0);

        // Miss load overtakes queued store drain
        base = n_req;
        @(negedge clk); drive(1, 0, 32'h500, 32'h1, 0);
        @(negedge clk); drive(1, 0, 32'h504, 32'h2, 0);
        @(negedge clk); drive(0, 1, 32'h400, 0, 3);
        #1 wait_unstall("t5 unstall", 40, n);
        @(posedge clk); #1;
        check("t5 wb_valid", 64'(ld_wb_valid), 1);
        check("t5 wb_addr", 64'(ld_wb_addr), 3);
        check("t5 wb_data", 64'(ld_wb_data), 64'hBEEF);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        wait_stb_empty("t5 drain", 100);
        check_req("t5 req0", base + 0, 1, 32'h500, 32'h1);
        check_req("t5 req1", base + 1, 0, 32'h400, 32'h0);
        check_req("t5 req2", base + 2, 1, 32'h504, 32'h2);

        // Reset while a read is outstanding
        lat  = 10;
        base = n_req;
        hs   = 1'b0;
        @(negedge clk); drive(0, 1, 32'h600, 0, 4);
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid) begin
                hs = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t6 read issued", 64'(hs), 1);
        @(posedge clk);
        @(negedge clk); rst = 1'b1; drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check_reset("t6 rst");
        @(negedge clk); rst = 1'b0; lat = 2;
        @(negedge clk); drive(1, 0, 32'h700, 32'h77, 0);
        #1 check("t6 st stall", 64'(ret_stall), 0);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        check("t6 no wb", 64'(ld_wb_valid), 0);
        wait_stb_empty("t6 drain", 100);
        check("t6 req count", 64'(n_req - base), 2);
        check_req("t6 req1", base + 1, 1, 32'h700, 32'h77);
        check("t6 mem 0x700", 64'(mem[32'h700 >> 2]), 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
